// File: rtl/seq_pkg.sv
// Shared types and helpers for the inter-layer map sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } seq_state_e;

  // Pixels in one square feature map.
  function automatic int pixels(input int width);
    return width * width;
  endfunction

endpackage

// File: rtl/map_fill_counter.sv
// Fill level of one buffered feature map. Saturates at Pixels and flags a
// write that arrives when the map is already full.
module map_fill_counter
  import seq_pkg::*;
#(
  parameter int Pixels = 16,
  parameter int CW     = $clog2(Pixels + 1)
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          ovf_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          full;

  assign full  = (cnt_q == CW'(Pixels));
  // Clear wins over a same-cycle write, so that write is dropped silently.
  assign ovf_o = inc_i & full & ~clr_i;
  assign cnt_o = cnt_q;

  // Next fill level: clear, count a write, or hold when saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)              cnt_d = '0;
    else if (inc_i && !full) cnt_d = cnt_q + CW'(1);
  end

  // Fill level register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/layer_sequencer.sv
// Streams buffered feature maps, one at a time, into the downstream layer and
// resets that layer between maps. Reads never overtake the map's fill level.
module layer_sequencer
  import seq_pkg::*;
#(
  parameter int  NumberOfK  = 4,
  parameter int  ImageWidth = 4,
  parameter int  Gap        = 2,
  localparam int Pixels     = pixels(ImageWidth),
  localparam int MW         = $clog2(NumberOfK),
  localparam int AW         = $clog2(Pixels)
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic [NumberOfK-1:0] wr_valid,
  input  logic                 layer_done,
  output logic                 rd_en,
  output logic [MW-1:0]        rd_map,
  output logic [AW-1:0]        rd_addr,
  output logic                 layer_rst_n,
  output logic                 up_ready,
  output logic                 image_done,
  output logic                 err
);

  localparam int CW = $clog2(Pixels + 1);
  localparam int GW = $clog2(Gap + 1);

  seq_state_e                  state_q, state_d;
  logic [MW-1:0]               cur_map_q, cur_map_d;
  logic [CW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [GW-1:0]               gap_q, gap_d;
  logic                        lrst_q;
  logic                        err_q;
  logic [NumberOfK-1:0][CW-1:0] wr_cnt;
  logic [NumberOfK-1:0]        ovf;
  logic                        clr_c;
  logic                        rd_en_c;
  logic                        done_c;

  // Writes are only accepted while up_ready; in DONE they vanish.
  assign up_ready = (state_q != S_DONE);

  for (genvar k = 0; k < NumberOfK; k++) begin : g_fill
    map_fill_counter #(
      .Pixels(Pixels),
      .CW    (CW)
    ) u_fill (
      .clk  (clk),
      .res_n(res_n),
      .inc_i(wr_valid[k] & up_ready),
      .clr_i(clr_c),
      .cnt_o(wr_cnt[k]),
      .ovf_o(ovf[k])
    );
  end

  assign rd_en       = rd_en_c;
  assign rd_map      = cur_map_q;
  assign rd_addr     = rd_ptr_q[AW-1:0];
  assign image_done  = done_c;
  assign err         = err_q;
  // lrst_q keeps the downstream layer in reset until the first edge after res_n.
  assign layer_rst_n = lrst_q & (state_q != S_FLUSH);

  // Sequencer next state, read strobe and end-of-image controls.
  always_comb begin
    state_d   = state_q;
    cur_map_d = cur_map_q;
    rd_ptr_d  = rd_ptr_q;
    gap_d     = gap_q;
    rd_en_c   = 1'b0;
    done_c    = 1'b0;
    clr_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cur_map_d = '0;
        rd_ptr_d  = '0;
        if (|wr_valid) state_d = S_STREAM;
      end
      S_STREAM: begin
        // Registered fill level: a pixel is readable the cycle after its write.
        if (rd_ptr_q < wr_cnt[cur_map_q]) begin
          rd_en_c  = 1'b1;
          rd_ptr_d = rd_ptr_q + CW'(1);
          if (rd_ptr_q == CW'(Pixels - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (layer_done) begin
          state_d = S_FLUSH;
          gap_d   = '0;
        end
      end
      S_FLUSH: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(Gap - 1)) begin
          gap_d    = '0;
          rd_ptr_d = '0;
          if (cur_map_q == MW'(NumberOfK - 1)) begin
            state_d = S_DONE;
          end else begin
            cur_map_d = cur_map_q + MW'(1);
            state_d   = S_STREAM;
          end
        end
      end
      S_DONE: begin
        done_c    = 1'b1;
        clr_c     = 1'b1;
        cur_map_d = '0;
        rd_ptr_d  = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, pointers, downstream reset release and sticky error.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q   <= S_IDLE;
      cur_map_q <= '0;
      rd_ptr_q  <= '0;
      gap_q     <= '0;
      lrst_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_map_q <= cur_map_d;
      rd_ptr_q  <= rd_ptr_d;
      gap_q     <= gap_d;
      lrst_q    <= 1'b1;
      err_q     <= err_q | (|ovf);
    end
  end

endmodule
